counter_cmd_seq: RTL

Front-end command sequencer for the 3-bit universal counter: turns three raw active-low board push-buttons and a data switch bank into clean, single-cycle `reset` / `set` / `load` / `data` commands plus a slow step tick. It sits directly upstream of the counter and runs in the same `clk` domain. The counter advances only on `ctr_tick` cycles, and every command is issued on a tick cycle.

---
 rtl/counter_cmd_pkg.sv | 11 +
 rtl/counter_cmd_seq_key_debounce.sv | 64 ++++++
 rtl/counter_cmd_seq.sv | 69 ++++++
 3 files changed

// File: rtl/counter_cmd_pkg.sv
// counter_cmd_pkg: shared command/debounce types and the command priority encoder.
package counter_cmd_pkg;
  typedef enum logic [1:0] {CMD_NONE, CMD_RESET, CMD_SET, CMD_LOAD} cmd_e;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_e;
  localparam int K_RESET = 0;
  localparam int K_SET   = 1;
  localparam int K_LOAD  = 2;
  function automatic cmd_e prio_cmd(input logic [2:0] req);
    return req[K_RESET] ? CMD_RESET : req[K_SET] ? CMD_SET : req[K_LOAD] ? CMD_LOAD : CMD_NONE;
  endfunction
endpackage

// File: rtl/counter_cmd_seq_key_debounce.sv
// key_debounce: two-flop synchronizer plus debounce FSM emitting a one-cycle press strobe.
module key_debounce
  import counter_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(DEBOUNCE_CYCLES);
  logic s1, s2;
  logic [CW-1:0] cnt, cnt_inc;
  deb_state_e state;
  assign cnt_inc = (cnt == C_MAX) ? cnt : cnt + 1'b1;
  // synchronizer resets to the released level so a key held through reset still yields one press
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      case (state)
        RELEASED: begin
          cnt <= '0;
          if (!s2) state <= PRESS_WAIT;
        end
        PRESS_WAIT:
          if (s2) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == C_LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            press <= 1'b1;
          end else cnt <= cnt_inc;
        PRESSED: begin
          cnt <= '0;
          if (s2) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT:
          if (!s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == C_LAST) begin
            state <= RELEASED;
            cnt   <= '0;
          end else cnt <= cnt_inc;
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: debounces three command keys and issues one registered command per step tick.
module counter_cmd_seq
  import counter_cmd_pkg::*;
#(
  parameter int DATA_W          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_reset_n,
  input  logic              key_set_n,
  input  logic              key_load_n,
  input  logic [DATA_W-1:0] sw_data,
  output logic              ctr_tick,
  output logic              ctr_reset,
  output logic              ctr_set,
  output logic              ctr_load,
  output logic [DATA_W-1:0] ctr_data,
  output logic              cmd_pending
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_PRE  = PW'(TICK_DIV - 2);
  logic [2:0] press, pend, pend_now, pend_next;
  logic [PW-1:0] pcnt;
  logic [DATA_W-1:0] stage, stage_now;
  logic tick_next;
  cmd_e cmd;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_reset (
    .clk(clk), .reset(reset), .key_n(key_reset_n), .press(press[K_RESET])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_set (
    .clk(clk), .reset(reset), .key_n(key_set_n), .press(press[K_SET])
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_load (
    .clk(clk), .reset(reset), .key_n(key_load_n), .press(press[K_LOAD])
  );
  // the command is decided on the edge entering the tick cycle so it lines up with ctr_tick;
  // pending is cleared on the edge leaving it, keeping any press that arrived during the tick
  assign pend_now  = pend | press;
  assign stage_now = press[K_LOAD] ? sw_data : stage;
  assign tick_next = (pcnt == P_PRE);
  assign cmd       = tick_next ? prio_cmd(pend_now) : CMD_NONE;
  assign pend_next = ctr_tick ? press : pend_now;
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt        <= '0;
      pend        <= '0;
      stage       <= '0;
      ctr_tick    <= 1'b0;
      ctr_reset   <= 1'b0;
      ctr_set     <= 1'b0;
      ctr_load    <= 1'b0;
      ctr_data    <= '0;
      cmd_pending <= 1'b0;
    end else begin
      pcnt        <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
      pend        <= pend_next;
      stage       <= stage_now;
      ctr_tick    <= tick_next;
      ctr_reset   <= (cmd == CMD_RESET);
      ctr_set     <= (cmd == CMD_SET);
      ctr_load    <= (cmd == CMD_LOAD);
      cmd_pending <= |pend_next;
      if (cmd == CMD_LOAD) ctr_data <= stage_now;
    end
  end
endmodule
